// File: rtl/hpdcache_flush_all_seq.sv
// Flush-all sequencer: walks every (set, way) of the directory, hands each valid dirty
// line to the flush controller, clears its dirty bit, then waits for the flush queue to drain.
module hpdcache_flush_all_seq #(
    parameter int unsigned SETS  = 64,
    parameter int unsigned WAYS  = 8,
    parameter int unsigned TAG_W = 20,
    parameter int unsigned CNT_W = $clog2(SETS*WAYS)+1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            req_i,
    output logic                            req_ready_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [CNT_W-1:0]                flushed_cnt_o,
    output logic                            dir_rd_o,
    input  logic                            dir_rd_gnt_i,
    output logic [$clog2(SETS)-1:0]         dir_rd_set_o,
    output logic [WAYS-1:0]                 dir_rd_way_o,
    input  logic                            dir_rd_valid_i,
    input  logic                            dir_rd_dirty_i,
    input  logic [TAG_W-1:0]                dir_rd_tag_i,
    output logic                            dir_clr_dirty_o,
    output logic [$clog2(SETS)-1:0]         dir_clr_set_o,
    output logic [WAYS-1:0]                 dir_clr_way_o,
    output logic                            flush_alloc_o,
    input  logic                            flush_alloc_ready_i,
    output logic [TAG_W+$clog2(SETS)-1:0]   flush_alloc_nline_o,
    output logic [WAYS-1:0]                 flush_alloc_way_o,
    input  logic                            flush_empty_i
);

    localparam int unsigned SET_W  = $clog2(SETS);
    localparam int unsigned WAY_IW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [SET_W-1:0]  LAST_SET = SET_W'(SETS-1);
    localparam logic [WAY_IW-1:0] LAST_WAY = WAY_IW'(WAYS-1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [2:0] {IDLE, READ, CHECK, ALLOC, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [SET_W-1:0]  set_q, set_d;
    logic [WAY_IW-1:0] way_q, way_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_q;
    logic              tag_en;
    logic              adv;
    logic              last_line;
    logic [WAYS-1:0]   way_oh;

    assign way_oh    = WAYS'(1) << way_q;
    assign last_line = (set_q == LAST_SET) && (way_q == LAST_WAY);

    // One address register serves read, clear and alloc: only one line is ever in flight.
    assign dir_rd_set_o        = set_q;
    assign dir_rd_way_o        = way_oh;
    assign dir_clr_set_o       = set_q;
    assign dir_clr_way_o       = way_oh;
    assign flush_alloc_nline_o = {tag_q, set_q};
    assign flush_alloc_way_o   = way_oh;
    assign flushed_cnt_o       = cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            set_q   <= '0;
            way_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tag is only consumed in ALLOC, which is always entered through a load.
    always_ff @(posedge clk_i) begin
        if (tag_en) tag_q <= dir_rd_tag_i;
    end

    always_comb begin
        state_d         = state_q;
        set_d           = set_q;
        way_d           = way_q;
        cnt_d           = cnt_q;
        tag_en          = 1'b0;
        adv             = 1'b0;
        req_ready_o     = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;
        dir_rd_o        = 1'b0;
        dir_clr_dirty_o = 1'b0;
        flush_alloc_o   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_i) begin
                    set_d   = '0;
                    way_d   = '0;
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                dir_rd_o = 1'b1;
                if (dir_rd_gnt_i) state_d = CHECK;
            end
            CHECK: begin
                if (dir_rd_valid_i && dir_rd_dirty_i) begin
                    tag_en  = 1'b1;
                    state_d = ALLOC;
                end else begin
                    adv = 1'b1;
                end
            end
            ALLOC: begin
                flush_alloc_o = 1'b1;
                if (flush_alloc_ready_i) begin
                    dir_clr_dirty_o = 1'b1;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    adv = 1'b1;
                end
            end
            DRAIN: begin
                if (flush_empty_i) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Way-major walk; the last line leaves the walk instead of issuing another read.
        if (adv) begin
            if (way_q == LAST_WAY) begin
                way_d = '0;
                set_d = set_q + 1'b1;
            end else begin
                way_d = way_q + 1'b1;
            end
            state_d = last_line ? DRAIN : READ;
        end
    end

endmodule

// File: tb/tb_hpdcache_flush_all_seq.sv
// Bench for hpdcache_flush_all_seq: a directory/flush-controller model drives the DUT and
// observed read, alloc and clear streams are compared to a walk-order reference list.
module tb_hpdcache_flush_all_seq;

    localparam int SETS   = 4;
    localparam int WAYS   = 2;
    localparam int TAG_W  = 8;
    localparam int SET_W  = 2;
    localparam int NL_W   = TAG_W + SET_W;
    localparam int CNT_W  = 4;
    localparam int NLINES = SETS * WAYS;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_i;
    logic              req_ready_o;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  flushed_cnt_o;
    logic              dir_rd_o;
    logic              dir_rd_gnt_i;
    logic [SET_W-1:0]  dir_rd_set_o;
    logic [WAYS-1:0]   dir_rd_way_o;
    logic              dir_rd_valid_i;
    logic              dir_rd_dirty_i;
    logic [TAG_W-1:0]  dir_rd_tag_i;
    logic              dir_clr_dirty_o;
    logic [SET_W-1:0]  dir_clr_set_o;
    logic [WAYS-1:0]   dir_clr_way_o;
    logic              flush_alloc_o;
    logic              flush_alloc_ready_i;
    logic [NL_W-1:0]   flush_alloc_nline_o;
    logic [WAYS-1:0]   flush_alloc_way_o;
    logic              flush_empty_i;

    always #5 clk_i = ~clk_i;

    hpdcache_flush_all_seq #(
        .SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .req_ready_o(req_ready_o),
        .busy_o(busy_o), .done_o(done_o), .flushed_cnt_o(flushed_cnt_o),
        .dir_rd_o(dir_rd_o), .dir_rd_gnt_i(dir_rd_gnt_i), .dir_rd_set_o(dir_rd_set_o),
        .dir_rd_way_o(dir_rd_way_o), .dir_rd_valid_i(dir_rd_valid_i),
        .dir_rd_dirty_i(dir_rd_dirty_i), .dir_rd_tag_i(dir_rd_tag_i),
        .dir_clr_dirty_o(dir_clr_dirty_o), .dir_clr_set_o(dir_clr_set_o),
        .dir_clr_way_o(dir_clr_way_o), .flush_alloc_o(flush_alloc_o),
        .flush_alloc_ready_i(flush_alloc_ready_i), .flush_alloc_nline_o(flush_alloc_nline_o),
        .flush_alloc_way_o(flush_alloc_way_o), .flush_empty_i(flush_empty_i)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Directory contents seen by the DUT
    logic             dv [SETS][WAYS];
    logic             dd [SETS][WAYS];
    logic [TAG_W-1:0] dt [SETS][WAYS];

    logic pend;
    int   pend_s, pend_w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int oh2i(input logic [WAYS-1:0] oh);
        for (int i = 0; i < WAYS; i++) if (oh[i]) return i;
        return -1;
    endfunction

    // mode 0: all valid clean, 1: all valid dirty, 2: random
    task automatic fill_dir(input int mode);
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                dv[s][w] = (mode == 2) ? 1'($urandom % 2) : 1'b1;
                dd[s][w] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom % 2);
                dt[s][w] = TAG_W'($urandom);
            end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " req_ready"}, 64'(req_ready_o), 64'd1);
        chk({nm, " busy"}, 64'(busy_o), 64'd0);
        chk({nm, " done"}, 64'(done_o), 64'd0);
        chk({nm, " cnt"}, 64'(flushed_cnt_o), 64'd0);
        chk({nm, " rd"}, 64'(dir_rd_o), 64'd0);
        chk({nm, " alloc"}, 64'(flush_alloc_o), 64'd0);
        chk({nm, " clr"}, 64'(dir_clr_dirty_o), 64'd0);
    endtask

    // gnt_mode 0: always, 1: toggling, 2: random. rdy_stall <0: random ready, else low cycles per alloc.
    // empty_rise: first cycle flush_empty_i is high. exp_done <0: timing not checked.
    task automatic run_op(input string nm, input int gnt_mode, input int rdy_stall,
                          input int empty_rise, input int exp_done, input bit spurious,
                          input int abort_at);
        int exp_s[$], exp_w[$];
        logic [NL_W-1:0] exp_nl[$];
        int rd_s[$], rd_w[$], al_w[$], cl_s[$], cl_w[$];
        logic [NL_W-1:0] al_nl[$];
        int done_cyc = -1, n_done = 0, stall = 0;
        int busy_err = 0, rdy_err = 0, rd_hold_err = 0, al_hold_err = 0, overlap_err = 0;
        bit p_rd = 0, p_al = 0, exp_busy;
        logic [SET_W-1:0] p_set = '0;
        logic [WAYS-1:0]  p_way = '0, p_alw = '0;
        logic [NL_W-1:0]  p_nl = '0;
        int exp_cnt;

        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (dv[s][w] && dd[s][w]) begin
                    exp_s.push_back(s);
                    exp_w.push_back(w);
                    exp_nl.push_back({dt[s][w], SET_W'(s)});
                end
        exp_cnt = (exp_s.size() > (2**CNT_W - 1)) ? (2**CNT_W - 1) : exp_s.size();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            req_i = (cyc == 0) || (spurious && (cyc == 3 || cyc == 4 || cyc == 20));
            case (gnt_mode)
                0:       dir_rd_gnt_i = 1'b1;
                1:       dir_rd_gnt_i = (cyc % 2 == 1);
                default: dir_rd_gnt_i = 1'($urandom % 2);
            endcase
            if (flush_alloc_o)
                flush_alloc_ready_i = (rdy_stall < 0) ? 1'($urandom % 2) : (stall >= rdy_stall);
            else
                flush_alloc_ready_i = 1'($urandom % 2);
            flush_empty_i = (cyc >= empty_rise);
            if (pend) begin
                dir_rd_valid_i = dv[pend_s][pend_w];
                dir_rd_dirty_i = dd[pend_s][pend_w];
                dir_rd_tag_i   = dt[pend_s][pend_w];
            end else begin
                dir_rd_valid_i = 1'($urandom % 2);
                dir_rd_dirty_i = 1'($urandom % 2);
                dir_rd_tag_i   = TAG_W'($urandom);
            end
            pend = 1'b0;
            #1;

            exp_busy = (cyc >= 1) && (done_cyc < 0);
            if (busy_o !== exp_busy) busy_err++;
            if (req_ready_o !== !exp_busy) rdy_err++;
            if (p_rd && (dir_rd_o !== 1'b1 || dir_rd_set_o !== p_set || dir_rd_way_o !== p_way))
                rd_hold_err++;
            if (p_al && (flush_alloc_o !== 1'b1 || flush_alloc_nline_o !== p_nl ||
                         flush_alloc_way_o !== p_alw))
                al_hold_err++;
            if (dir_rd_o && flush_alloc_o) overlap_err++;

            if (abort_at >= 0 && flush_alloc_o && al_nl.size() == abort_at) begin
                #1 rst_i = 1'b1;
                #1;
                check_reset_outputs({nm, " async-rst"});
                pend = 1'b0;
                return;
            end

            if (dir_rd_o && dir_rd_gnt_i) begin
                rd_s.push_back(int'(dir_rd_set_o));
                rd_w.push_back(oh2i(dir_rd_way_o));
                pend   = 1'b1;
                pend_s = int'(dir_rd_set_o);
                pend_w = oh2i(dir_rd_way_o);
            end
            if (flush_alloc_o && flush_alloc_ready_i) begin
                al_nl.push_back(flush_alloc_nline_o);
                al_w.push_back(oh2i(flush_alloc_way_o));
                stall = 0;
            end else if (flush_alloc_o) begin
                stall++;
            end
            if (dir_clr_dirty_o) begin
                cl_s.push_back(int'(dir_clr_set_o));
                cl_w.push_back(oh2i(dir_clr_way_o));
                if (oh2i(dir_clr_way_o) >= 0) dd[dir_clr_set_o][oh2i(dir_clr_way_o)] = 1'b0;
            end
            p_rd  = dir_rd_o && !dir_rd_gnt_i;
            p_set = dir_rd_set_o;
            p_way = dir_rd_way_o;
            p_al  = flush_alloc_o && !flush_alloc_ready_i;
            p_nl  = flush_alloc_nline_o;
            p_alw = flush_alloc_way_o;

            if (done_o === 1'b1) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk({nm, " cnt@done"}, 64'(flushed_cnt_o), 64'(exp_cnt));
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 2) break;
            @(posedge clk_i);
            #1;
        end

        chk({nm, " done seen"}, 64'(done_cyc >= 0), 64'd1);
        chk({nm, " done pulses"}, 64'(n_done), 64'd1);
        if (exp_done >= 0) chk({nm, " done cycle"}, 64'(done_cyc), 64'(exp_done));
        chk({nm, " cnt held"}, 64'(flushed_cnt_o), 64'(exp_cnt));
        chk({nm, " busy"}, 64'(busy_err), 64'd0);
        chk({nm, " req_ready"}, 64'(rdy_err), 64'd0);
        chk({nm, " rd hold"}, 64'(rd_hold_err), 64'd0);
        chk({nm, " alloc hold"}, 64'(al_hold_err), 64'd0);
        chk({nm, " rd/alloc overlap"}, 64'(overlap_err), 64'd0);
        chk({nm, " n reads"}, 64'(rd_s.size()), 64'(NLINES));
        for (int i = 0; i < rd_s.size() && i < NLINES; i++)
            chk($sformatf("%s read%0d", nm, i), 64'(rd_s[i] * WAYS + rd_w[i]), 64'(i));
        chk({nm, " n allocs"}, 64'(al_nl.size()), 64'(exp_nl.size()));
        chk({nm, " n clears"}, 64'(cl_s.size()), 64'(exp_s.size()));
        for (int i = 0; i < al_nl.size() && i < exp_nl.size(); i++) begin
            chk($sformatf("%s alloc%0d nline", nm, i), 64'(al_nl[i]), 64'(exp_nl[i]));
            chk($sformatf("%s alloc%0d way", nm, i), 64'(al_w[i]), 64'(exp_w[i]));
        end
        for (int i = 0; i < cl_s.size() && i < exp_s.size(); i++)
            chk($sformatf("%s clr%0d", nm, i), 64'(cl_s[i] * WAYS + cl_w[i]),
                64'(exp_s[i] * WAYS + exp_w[i]));
    endtask

    initial begin
        rst_i = 1'b1;
        req_i = 1'b0;
        dir_rd_gnt_i = 1'b0;
        dir_rd_valid_i = 1'b0;
        dir_rd_dirty_i = 1'b0;
        dir_rd_tag_i = '0;
        flush_alloc_ready_i = 1'b0;
        flush_empty_i = 1'b1;
        pend = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // All clean: 16 walk cycles + 1 drain, done at cycle 18
        fill_dir(0);
        run_op("clean", 0, 0, 0, 18, 1'b0, -1);

        // Single dirty line (set 2, way 1), tag 0x5A
        fill_dir(0);
        dd[2][1] = 1'b1;
        dt[2][1] = 8'h5A;
        run_op("one-dirty", 0, 0, 0, 19, 1'b0, -1);
        chk("one-dirty dir cleared", 64'(dd[2][1]), 64'd0);

        // All dirty with ready low 3 cycles per alloc: 8 lines * 6 cycles + 1 drain
        fill_dir(1);
        run_op("all-dirty-stall", 0, 3, 0, 50, 1'b0, -1);

        // Grant toggling with a random directory
        fill_dir(2);
        run_op("gnt-toggle", 1, 1, 0, -1, 1'b0, -1);

        // Drain held 10 cycles, spurious requests while busy
        fill_dir(0);
        run_op("drain-wait", 0, 0, 27, 28, 1'b1, -1);

        // Reset while an alloc is stalled mid-walk, then a clean restart
        fill_dir(1);
        run_op("abort", 0, 1000, 0, -1, 1'b0, 2);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check_reset_outputs("post-rst");
        fill_dir(1);
        run_op("restart", 0, 0, 0, 26, 1'b0, -1);

        // Randomized directory, grant, ready and drain timing
        for (int r = 0; r < 4; r++) begin
            fill_dir(2);
            run_op($sformatf("rand%0d", r), 2, -1, int'($urandom_range(0, 60)), -1, 1'b0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
